alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/seq_pkg.sv | 34 +++
 rtl/iter_counter.sv | 38 +++
 rtl/alu_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared opcodes, FSM state encoding and size defaults for the
//               ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int ROM_AW_DEFAULT = 9;
    localparam int DW_DEFAULT     = 16;

    localparam logic [7:0] c_OP_ADD  = 8'h00;
    localparam logic [7:0] c_OP_SUB  = 8'h01;
    localparam logic [7:0] c_OP_MUL  = 8'h02;
    localparam logic [7:0] c_OP_DIV  = 8'h03;
    localparam logic [7:0] c_OP_HALT = 8'hFF;

    // S_LOAD_B is the cycle in which the B operand byte is captured.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH_OP = 4'd1,
        S_FETCH_A  = 4'd2,
        S_FETCH_B  = 4'd3,
        S_LOAD_B   = 4'd4,
        S_EXEC     = 4'd5,
        S_MUL_LOOP = 4'd6,
        S_DIV_LOOP = 4'd7,
        S_DONE     = 4'd8,
        S_HALT     = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/iter_counter.sv
`default_nettype none
// ============================================================================
// Module      : iter_counter
// Description : Loadable up/down iteration counter with zero detect.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Fetches 3-byte instructions from a synchronous ROM and runs
//               ADD/SUB/MUL/DIV on an external shared adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import seq_pkg::*;
#(
    parameter int ROM_AW = ROM_AW_DEFAULT,
    parameter int DW     = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic              alu_op,
    input  logic [DW-1:0]     alu_y,
    output logic [DW-1:0]     result,
    output logic [DW-1:0]     remainder,
    output logic              result_valid,
    output logic              busy,
    output logic              halted,
    output logic              div_zero
);

    // Last pc from which a whole 3-byte instruction can still be fetched.
    localparam logic [ROM_AW-1:0] c_PC_LIMIT = ROM_AW'((1 << ROM_AW) - 3);

    state_t            r_state, w_next;
    logic [ROM_AW-1:0] r_pc;
    logic [7:0]        r_opcode;
    logic [DW-1:0]     r_a, r_b, r_acc;
    logic              w_cnt_load, w_cnt_dec, w_cnt_inc, w_cnt_zero;
    logic [DW-1:0]     w_cnt_val, w_cnt;
    logic              w_pc_over;

    assign w_pc_over = (r_pc > c_PC_LIMIT);

    iter_counter #(.W(DW)) u_iter (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .i_inc      (w_cnt_inc),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        rom_addr   = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_dec  = 1'b0;
        w_cnt_inc  = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: if (start) w_next = S_FETCH_OP;
            S_FETCH_OP: begin
                rom_addr = r_pc;
                w_next   = w_pc_over ? S_HALT : S_FETCH_A;
            end
            S_FETCH_A: begin
                rom_addr = r_pc + ROM_AW'(1);
                w_next   = S_FETCH_B;
            end
            S_FETCH_B: begin
                rom_addr = r_pc + ROM_AW'(2);
                w_next   = S_LOAD_B;
            end
            S_LOAD_B: w_next = S_EXEC;
            S_EXEC: begin
                case (r_opcode)
                    c_OP_ADD, c_OP_SUB: begin
                        alu_a  = r_a;
                        alu_b  = r_b;
                        alu_op = (r_opcode == c_OP_SUB);
                        w_next = S_DONE;
                    end
                    c_OP_MUL: begin
                        w_cnt_load = 1'b1;
                        w_cnt_val  = r_b;
                        w_next     = S_MUL_LOOP;
                    end
                    c_OP_DIV: begin
                        if (r_b == '0) begin
                            w_next = S_DONE;
                        end else begin
                            w_cnt_load = 1'b1;
                            w_next     = S_DIV_LOOP;
                        end
                    end
                    default: w_next = S_HALT;
                endcase
            end
            S_MUL_LOOP: begin
                alu_a = r_acc;
                alu_b = r_a;
                if (w_cnt_zero) w_next = S_DONE;
                else            w_cnt_dec = 1'b1;
            end
            S_DIV_LOOP: begin
                alu_a  = r_acc;
                alu_b  = r_b;
                alu_op = 1'b1;
                if (r_acc >= r_b) w_cnt_inc = 1'b1;
                else              w_next    = S_DONE;
            end
            S_DONE:  w_next = S_FETCH_OP;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and status registers; result_valid fires on entry to S_DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= '0;
            r_opcode     <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            result       <= '0;
            remainder    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            div_zero     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc     <= '0;
                        halted   <= 1'b0;
                        div_zero <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_FETCH_OP: begin
                    if (w_pc_over) begin
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                S_FETCH_A: r_opcode <= rom_data;
                S_FETCH_B: r_a      <= DW'(rom_data);
                S_LOAD_B:  r_b      <= DW'(rom_data);
                S_EXEC: begin
                    r_pc <= r_pc + ROM_AW'(3);
                    case (r_opcode)
                        c_OP_ADD, c_OP_SUB: begin
                            result       <= alu_y;
                            remainder    <= '0;
                            result_valid <= 1'b1;
                        end
                        c_OP_MUL: r_acc <= '0;
                        c_OP_DIV: begin
                            if (r_b == '0) begin
                                result       <= '0;
                                remainder    <= r_a;
                                div_zero     <= 1'b1;
                                result_valid <= 1'b1;
                            end else begin
                                r_acc <= r_a;
                            end
                        end
                        default: begin
                            halted <= 1'b1;
                            busy   <= 1'b0;
                        end
                    endcase
                end
                S_MUL_LOOP: begin
                    if (!w_cnt_zero) begin
                        r_acc <= alu_y;
                    end else begin
                        result       <= r_acc;
                        remainder    <= '0;
                        result_valid <= 1'b1;
                    end
                end
                S_DIV_LOOP: begin
                    if (r_acc >= r_b) begin
                        r_acc <= alu_y;
                    end else begin
                        result       <= w_cnt;
                        remainder    <= r_acc;
                        result_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed table-driven bench for alu_sequencer with a ROM and
//               adder/subtractor model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [15:0] alu_a, alu_b, alu_y, result, remainder;
    logic        alu_op, result_valid, busy, halted, div_zero;

    logic [7:0]  mem [0:511];

    int n_tests = 0;
    int n_fail  = 0;

    alu_sequencer #(.ROM_AW(9), .DW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_y        (alu_y),
        .result       (result),
        .remainder    (remainder),
        .result_valid (result_valid),
        .busy         (busy),
        .halted       (halted),
        .div_zero     (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    assign alu_y = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic [15:0] rem;
        int          cyc;
        logic        dz;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
    endtask

    // Leaves the caller at the falling edge inside cycle 0.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit) begin
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_halt(input int limit, output int pulses, output bit ok);
        pulses = 0;
        ok     = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (halted) begin
                ok = 1'b1;
                break;
            end
            if (result_valid) pulses++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  cyc, pulses;
        bit  ok;
        string nm;

        vecs[0]  = '{8'h00, 8'd5,   8'd3,   16'd8,      16'd0, 5,   1'b0};
        vecs[1]  = '{8'h01, 8'd3,   8'd5,   16'hFFFE,   16'd0, 5,   1'b0};
        vecs[2]  = '{8'h02, 8'd200, 8'd200, 16'h9C40,   16'd0, 206, 1'b0};
        vecs[3]  = '{8'h02, 8'd7,   8'd0,   16'd0,      16'd0, 6,   1'b0};
        vecs[4]  = '{8'h03, 8'd17,  8'd5,   16'd3,      16'd2, 9,   1'b0};
        vecs[5]  = '{8'h03, 8'd3,   8'd7,   16'd0,      16'd3, 6,   1'b0};
        vecs[6]  = '{8'h03, 8'd9,   8'd0,   16'd0,      16'd9, 5,   1'b1};
        vecs[7]  = '{8'h00, 8'd255, 8'd255, 16'd510,    16'd0, 5,   1'b0};
        vecs[8]  = '{8'h02, 8'd255, 8'd255, 16'hFE01,   16'd0, 261, 1'b0};
        vecs[9]  = '{8'h03, 8'd255, 8'd1,   16'd255,    16'd0, 261, 1'b0};
        vecs[10] = '{8'h01, 8'd0,   8'd0,   16'd0,      16'd0, 5,   1'b0};

        clear_rom();
        repeat (2) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_remainder", remainder, 0);
        check("rst_flags", {result_valid, busy, halted, div_zero}, 0);
        check("rst_rom_addr", rom_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            clear_rom();
            mem[0] = vecs[v].op;
            mem[1] = vecs[v].a;
            mem[2] = vecs[v].b;
            pulse_start();
            nm = $sformatf("v%0d", v);
            check({nm, "_busy_c0"}, busy, 1);
            check({nm, "_addr_c0"}, rom_addr, 0);
            wait_valid(400, cyc, ok);
            check({nm, "_valid_seen"}, ok, 1);
            check({nm, "_cycle"}, cyc, vecs[v].cyc);
            check({nm, "_result"}, result, vecs[v].res);
            check({nm, "_remainder"}, remainder, vecs[v].rem);
            check({nm, "_div_zero"}, div_zero, vecs[v].dz);
            @(negedge clk);
            check({nm, "_valid_pulse"}, result_valid, 0);
            wait_halt(30, pulses, ok);
            check({nm, "_halted"}, {halted, busy}, 2'b10);
            check({nm, "_dz_sticky"}, div_zero, vecs[v].dz);
        end

        // ADD, MUL, HALT program: two results then halt
        clear_rom();
        mem[0] = 8'h00; mem[1] = 8'd5; mem[2] = 8'd3;
        mem[3] = 8'h02; mem[4] = 8'd4; mem[5] = 8'd6;
        pulse_start();
        wait_valid(50, cyc, ok);
        check("prog_r1", result, 8);
        @(negedge clk);
        wait_valid(50, cyc, ok);
        check("prog_r2_seen", ok, 1);
        check("prog_r2", result, 24);
        check("prog_busy_mid", busy, 1);
        @(negedge clk);
        wait_halt(30, pulses, ok);
        check("prog_halt", {halted, busy, 8'(pulses)}, {1'b1, 1'b0, 8'd0});

        // Illegal opcode behaves as halt, no result
        clear_rom();
        mem[0] = 8'h10;
        pulse_start();
        wait_halt(30, pulses, ok);
        check("illegal_halt", {halted, busy}, 2'b10);
        check("illegal_pulses", pulses, 0);

        // ROM filled with ADD 1,1: must halt at the end, not wrap
        for (int i = 0; i < 512; i++) mem[i] = ((i % 3) == 0) ? 8'h00 : 8'h01;
        pulse_start();
        wait_halt(3000, pulses, ok);
        check("pc_end_halted", {ok, halted, busy}, 3'b110);
        check("pc_end_pulses", pulses, 170);
        check("pc_end_result", result, 2);

        // Asynchronous reset in the middle of a long multiply
        clear_rom();
        mem[0] = 8'h02; mem[1] = 8'd200; mem[2] = 8'd200;
        pulse_start();
        repeat (60) @(negedge clk);
        check("mid_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_result", result, 0);
        check("arst_flags", {result_valid, busy, halted, div_zero}, 0);
        check("arst_alu", {alu_a, alu_b, alu_op}, 0);
        check("arst_rom_addr", rom_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        mem[0] = 8'h00; mem[1] = 8'd5; mem[2] = 8'd3;
        @(negedge clk);
        pulse_start();
        wait_valid(50, cyc, ok);
        check("rerun_cycle", cyc, 5);
        check("rerun_result", result, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
